gate_resp_checker: RTL and testbench

- Hardware self-checking harness for the basic two-input gate library: and_gate, or_gate, not_gate and nand_gate.
- Drives the shared gate_a/gate_b stimulus pair through all four input combinations and waits a settle interval after each one.
- Samples the four gate outputs and compares them against the expected truth table.
- Reports a per-gate failure mask, an error count and a pass flag.
- Sits on the response side of the gate library: it generates stimulus and also consumes and judges the outputs.

---
 rtl/gate_resp_checker.sv | 196 +++++++++++++++++++
 tb/tb_gate_resp_checker.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_resp_checker.sv
// -----------------------------------------------------------------------------
// gate_resp_checker
//
// Self-checking harness for the basic two-input gate library (AND, OR, NOT,
// NAND). On a start request it walks the shared gate_a/gate_b stimulus pair
// through the four input combinations {a,b} = 11, 10, 00, 01. Each vector is
// held for SETTLE_CYC cycles and then judged in one CHECK cycle against the
// expected truth table.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (synchronous release expected)
//   start      single-cycle run request, honoured only in IDLE or DONE
//   gate_a/b   stimulus driven to the gate inputs
//   and_in,
//   or_in,
//   not_in,
//   nand_in    observed gate outputs (not_gate is fed from gate_a)
//   busy       high while a run is in progress
//   done       high from end of run until next accepted start or reset
//   pass       valid with done; 1 = no mismatch seen during the run
//   fail_mask  sticky per-gate mismatch flags {NAND, NOT, OR, AND}
//   err_count  number of vectors with at least one mismatch (saturating)
//   vec_idx    index of the vector currently applied
// -----------------------------------------------------------------------------
module gate_resp_checker #(
  parameter int SETTLE_CYC = 2,
  parameter int ERR_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             gate_a,
  output logic             gate_b,
  input  logic             and_in,
  input  logic             or_in,
  input  logic             not_in,
  input  logic             nand_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       fail_mask,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       vec_idx
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Settle counter only has to reach SETTLE_CYC-1.
  localparam int              CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  // Stimulus pair {a,b} for each vector index.
  function automatic logic [1:0] vec_ab(input logic [1:0] idx);
    logic [1:0] ab;
    case (idx)
      2'd0:    ab = 2'b11;
      2'd1:    ab = 2'b10;
      2'd2:    ab = 2'b00;
      default: ab = 2'b01;
    endcase
    return ab;
  endfunction

  state_t           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [1:0]       vec_idx_q,   vec_idx_d;
  logic             gate_a_q,    gate_a_d;
  logic             gate_b_q,    gate_b_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic             pass_q,      pass_d;
  logic [3:0]       fail_mask_q, fail_mask_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  // Expected outputs for the vector currently applied; bit order matches
  // fail_mask: {NAND, NOT, OR, AND}.
  logic [1:0] cur_ab;
  logic       exp_a;
  logic       exp_b;
  logic [3:0] exp_bits;
  logic [3:0] obs_bits;
  logic [3:0] mism;

  assign cur_ab   = vec_ab(vec_idx_q);
  assign exp_a    = cur_ab[1];
  assign exp_b    = cur_ab[0];
  assign exp_bits = {~(exp_a & exp_b), ~exp_a, exp_a | exp_b, exp_a & exp_b};
  assign obs_bits = {nand_in, not_in, or_in, and_in};

  // Case-inequality so that an X or Z on an observed output is a mismatch.
  for (genvar gi = 0; gi < 4; gi++) begin : g_cmp
    assign mism[gi] = (obs_bits[gi] !== exp_bits[gi]);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vec_idx_d   = vec_idx_q;
    gate_a_d    = gate_a_q;
    gate_b_d    = gate_b_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_mask_d = fail_mask_q;
    err_count_d = err_count_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          done_d      = 1'b0;
          pass_d      = 1'b0;
          fail_mask_d = 4'b0000;
          err_count_d = '0;
          vec_idx_d   = 2'd0;
          gate_a_d    = 1'b1;
          gate_b_d    = 1'b1;
          cnt_d       = '0;
          busy_d      = 1'b1;
          state_d     = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_CHECK: begin
        fail_mask_d = fail_mask_q | mism;
        if ((|mism) && (err_count_q != ERR_MAX)) begin
          err_count_d = err_count_q + 1'b1;
        end
        if (vec_idx_q != 2'd3) begin
          vec_idx_d = vec_idx_q + 2'd1;
          {gate_a_d, gate_b_d} = vec_ab(vec_idx_q + 2'd1);
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else begin
          // Verdict includes this cycle's mismatches.
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = ((fail_mask_q | mism) == 4'b0000);
          state_d = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      vec_idx_q   <= 2'd0;
      gate_a_q    <= 1'b0;
      gate_b_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= 4'b0000;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vec_idx_q   <= vec_idx_d;
      gate_a_q    <= gate_a_d;
      gate_b_q    <= gate_b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_mask_q <= fail_mask_d;
      err_count_q <= err_count_d;
    end
  end

  assign gate_a    = gate_a_q;
  assign gate_b    = gate_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_mask_q;
  assign err_count = err_count_q;
  assign vec_idx   = vec_idx_q;

endmodule

// File: tb/tb_gate_resp_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_resp_checker
//
// Two checker instances share clock and reset: u_dut (ERR_W=4) sees a gate
// model with selectable faults, u_dut2 (ERR_W=2) sees fully inverted gates to
// exercise err_count saturation. Expected run results are queued when a run
// is started; monitors pop and compare when done rises, and also track the
// busy length and the applied stimulus sequence.
// -----------------------------------------------------------------------------
module tb_gate_resp_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       pass;
    logic [3:0] mask;
    int         err;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  int total = 0;
  int bad   = 0;

  // fault mode for u_dut: 0 good, 1 and tied 0, 2 not wrong polarity
  int mode = 0;

  logic       rst_n;
  logic       start;
  logic       start2;
  logic       gate_a, gate_b, and_in, or_in, not_in, nand_in;
  logic       busy, done, pass;
  logic [3:0] fail_mask;
  logic [3:0] err_count;
  logic [1:0] vec_idx;

  logic       gate_a2, gate_b2, and2, or2, not2, nand2;
  logic       busy2, done2, pass2;
  logic [3:0] fail_mask2;
  logic [1:0] err_count2;
  logic [1:0] vec_idx2;

  assign and_in  = (mode == 1) ? 1'b0 : (gate_a & gate_b);
  assign or_in   = gate_a | gate_b;
  assign not_in  = (mode == 2) ? gate_a : ~gate_a;
  assign nand_in = ~(gate_a & gate_b);

  assign and2  = ~(gate_a2 & gate_b2);
  assign or2   = ~(gate_a2 | gate_b2);
  assign not2  = gate_a2;
  assign nand2 = gate_a2 & gate_b2;

  gate_resp_checker #(.SETTLE_CYC(2), .ERR_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .gate_a(gate_a), .gate_b(gate_b),
    .and_in(and_in), .or_in(or_in), .not_in(not_in), .nand_in(nand_in),
    .busy(busy), .done(done), .pass(pass),
    .fail_mask(fail_mask), .err_count(err_count), .vec_idx(vec_idx)
  );

  gate_resp_checker #(.SETTLE_CYC(2), .ERR_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .gate_a(gate_a2), .gate_b(gate_b2),
    .and_in(and2), .or_in(or2), .not_in(not2), .nand_in(nand2),
    .busy(busy2), .done(done2), .pass(pass2),
    .fail_mask(fail_mask2), .err_count(err_count2), .vec_idx(vec_idx2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  // Monitor for u_dut: stimulus sequence 11,10,00,01 each held 3 samples,
  // busy for 12 samples, verdict compared against the queued expectation.
  task automatic monitor1();
    logic [1:0] seq_tab [4];
    int  busy_cnt = 0;
    bit  seq_ok   = 1'b1;
    bit  busy_prev = 1'b0;
    bit  done_prev = 1'b0;
    exp_t e;
    seq_tab[0] = 2'b11; seq_tab[1] = 2'b10; seq_tab[2] = 2'b00; seq_tab[3] = 2'b01;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt = 0; busy_prev = 1'b0; done_prev = 1'b0; seq_ok = 1'b1;
      end else begin
        if (busy && !busy_prev) begin
          busy_cnt = 0;
          seq_ok   = 1'b1;
        end
        if (busy) begin
          if (busy_cnt < 12) begin
            if ({gate_a, gate_b} !== seq_tab[busy_cnt / 3]) seq_ok = 1'b0;
            if (vec_idx !== 2'(busy_cnt / 3)) seq_ok = 1'b0;
          end
          busy_cnt++;
        end
        if (done && !done_prev) begin
          if (q1.size() == 0) begin
            chk("dut1_unexpected_done", 32'd1, 32'd0);
          end else begin
            e = q1.pop_front();
            $display("run result: pass=%0b mask=%b err=%0d busy_cycles=%0d",
                     pass, fail_mask, err_count, busy_cnt);
            chk("dut1_pass",        32'(pass),      32'(e.pass));
            chk("dut1_fail_mask",   32'(fail_mask), 32'(e.mask));
            chk("dut1_err_count",   32'(err_count), 32'(e.err));
            chk("dut1_busy_cycles", 32'(busy_cnt),  32'd12);
            chk("dut1_stim_seq",    32'(seq_ok),    32'd1);
          end
        end
        busy_prev = busy;
        done_prev = done;
      end
    end
  endtask

  task automatic monitor2();
    bit   done_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        done_prev = 1'b0;
      end else begin
        if (done2 && !done_prev) begin
          if (q2.size() == 0) begin
            chk("dut2_unexpected_done", 32'd1, 32'd0);
          end else begin
            e = q2.pop_front();
            $display("run2 result: pass=%0b mask=%b err=%0d", pass2, fail_mask2, err_count2);
            chk("dut2_pass",      32'(pass2),      32'(e.pass));
            chk("dut2_fail_mask", 32'(fail_mask2), 32'(e.mask));
            chk("dut2_err_sat",   32'(err_count2), 32'(e.err));
          end
        end
        done_prev = done2;
      end
    end
  endtask

  task automatic pulse_start(input bit which);
    @(negedge clk);
    if (which) start2 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic push1(input logic p, input logic [3:0] m, input int err);
    exp_t e;
    e.pass = p; e.mask = m; e.err = err;
    q1.push_back(e);
  endtask

  task automatic wait_done(input bit which, input string nm);
    for (int i = 0; i < 40; i++) begin
      if ((which ? done2 : done) === 1'b1) return;
      @(negedge clk);
    end
    chk({nm, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
    chk({tag, "_pass"},      32'(pass),      32'd0);
    chk({tag, "_fail_mask"}, 32'(fail_mask), 32'd0);
    chk({tag, "_err_count"}, 32'(err_count), 32'd0);
    chk({tag, "_vec_idx"},   32'(vec_idx),   32'd0);
    chk({tag, "_gate_ab"},   32'({gate_a, gate_b}), 32'd0);
  endtask

  task automatic stimulus();
    exp_t e;
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; mode = 0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Good gates.
    push1(1'b1, 4'b0000, 0);
    pulse_start(1'b0);
    wait_done(1'b0, "run_good");
    repeat (3) @(negedge clk);
    chk("done_held",   32'(done), 32'd1);
    chk("gate_ab_hold", 32'({gate_a, gate_b}), 32'b01);

    // and_in stuck at 0.
    mode = 1;
    push1(1'b0, 4'b0001, 1);
    pulse_start(1'b0);
    wait_done(1'b0, "run_and0");
    @(negedge clk);

    // Restart from DONE; clears on the accept edge, stray starts ignored.
    push1(1'b0, 4'b0001, 1);
    pulse_start(1'b0);
    chk("restart_done_low", 32'(done),      32'd0);
    chk("restart_err_clr",  32'(err_count), 32'd0);
    chk("restart_mask_clr", 32'(fail_mask), 32'd0);
    chk("restart_busy",     32'(busy),      32'd1);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, "run_restart");
    @(negedge clk);

    // not_in wrong polarity.
    mode = 2;
    push1(1'b0, 4'b0100, 4);
    pulse_start(1'b0);
    wait_done(1'b0, "run_notpol");
    @(negedge clk);

    // Reset mid-run: no queued expectation, run must be aborted.
    mode = 0;
    pulse_start(1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_after_reset_busy", 32'(busy), 32'd0);
    chk("idle_after_reset_done", 32'(done), 32'd0);

    push1(1'b1, 4'b0000, 0);
    pulse_start(1'b0);
    wait_done(1'b0, "run_after_reset");
    @(negedge clk);

    // Saturating counter on the ERR_W=2 instance.
    e.pass = 1'b0; e.mask = 4'b1111; e.err = 3;
    q2.push_back(e);
    pulse_start(1'b1);
    wait_done(1'b1, "run_sat");
    repeat (2) @(negedge clk);

    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);
  endtask

  initial begin
    fork
      monitor1();
      monitor2();
      stimulus();
    join_any
    disable fork;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
